// File: rtl/util_axis_pkg.sv
// Shared types for the AXI-Stream framer: capture FSM states and the tagged word
// carried through the output skid buffer.
package util_axis_pkg;

    localparam int unsigned SAMPLE_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } framer_state_e;

    // The data field is fixed at SAMPLE_WIDTH; the framer's DATA_WIDTH must match.
    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] data;
        logic                    tlast;
        logic                    tuser;
    } tagged_word_t;

endpackage

// File: rtl/util_axis_framer_if.sv
// AXI-Stream bundle used on both sides of the framer.
// Handshake: a word transfers on a rising edge where tvalid and tready are both high;
// once tvalid is raised the source holds tdata/tlast/tuser stable until that edge.
interface util_axis_framer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tuser;

    modport master (output tvalid, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/util_axis_skid.sv
// Two-entry skid buffer over a tagged word. Entry 0 drives the outputs directly and
// in_ready is registered from the next-cycle fill level, so no input reaches an output.
module util_axis_skid
    import util_axis_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_enable,
    input  logic         in_valid,
    output logic         in_ready,
    input  tagged_word_t in_word,
    output logic         out_valid,
    input  logic         out_ready,
    output tagged_word_t out_word,
    output logic         empty_next
);
    tagged_word_t word0_q, word1_q, word0_d, word1_d;
    logic         v0_q, v1_q, v0_d, v1_d;
    logic         push, pop;

    assign push = in_valid && in_ready;
    assign pop  = v0_q && out_ready;

    always_comb begin
        word0_d = word0_q;
        word1_d = word1_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        if (flush) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!v0_q) begin
                        word0_d = in_word;
                        v0_d    = 1'b1;
                    end else begin
                        word1_d = in_word;
                        v1_d    = 1'b1;
                    end
                end
                2'b01: begin
                    word0_d = word1_q;
                    v0_d    = v1_q;
                    v1_d    = 1'b0;
                end
                2'b11: begin
                    // The in-flight word lands behind whatever is still queued.
                    if (v1_q) begin
                        word0_d = word1_q;
                        word1_d = in_word;
                    end else begin
                        word0_d = in_word;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word0_q  <= '0;
            word1_q  <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            word0_q  <= word0_d;
            word1_q  <= word1_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            in_ready <= in_enable && !(v0_d && v1_d);
        end
    end

    assign out_valid  = v0_q;
    assign out_word   = word0_q;
    assign empty_next = !v0_d;

endmodule

// File: rtl/util_axis_framer.sv
// Cuts a free-running sample stream into AXI-Stream frames of programmable length,
// tagging tuser/tlast at the input and emitting through a registered skid buffer.
module util_axis_framer
    import util_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                 aclk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [LEN_WIDTH-1:0] cfg_frame_len,
    input  logic [LEN_WIDTH-1:0] cfg_num_frames,
    util_axis_framer_if.slave    s_axis_data,
    util_axis_framer_if.master   m_axis,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [LEN_WIDTH-1:0] frame_cnt,
    output framer_state_e        dbg_state
);
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    framer_state_e        state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, num_q, word_idx_q, in_frames_q;
    logic                 start_ok, abort_ok, accept, last_in, final_in, out_pop;
    logic                 skid_empty_next;
    tagged_word_t         in_word, out_word;
    logic                 unused_in_tags;

    assign unused_in_tags = ^{s_axis_data.tlast, s_axis_data.tuser};

    assign abort_ok = cfg_abort && (state_q == ST_RUN || state_q == ST_DRAIN);
    assign start_ok = cfg_start && !cfg_abort && (state_q == ST_IDLE) && (cfg_frame_len != '0);
    assign accept   = s_axis_data.tvalid && s_axis_data.tready;
    assign last_in  = (word_idx_q == len_q - ONE);
    // Completion is counted at the input so upstream stops right after the last word.
    assign final_in = accept && last_in && (num_q != '0) && (in_frames_q == num_q - ONE);
    assign out_pop  = m_axis.tvalid && m_axis.tready;

    assign in_word = '{data: s_axis_data.tdata, tlast: last_in, tuser: (word_idx_q == '0)};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (abort_ok)      state_d = ST_IDLE;
                else if (final_in) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort_ok)             state_d = ST_IDLE;
                else if (skid_empty_next) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            num_q       <= '0;
            word_idx_q  <= '0;
            in_frames_q <= '0;
            frame_cnt   <= '0;
            aborted     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                len_q       <= cfg_frame_len;
                num_q       <= cfg_num_frames;
                word_idx_q  <= '0;
                in_frames_q <= '0;
                frame_cnt   <= '0;
                aborted     <= 1'b0;
            end else begin
                if (accept && state_q == ST_RUN) begin
                    word_idx_q <= last_in ? '0 : word_idx_q + ONE;
                    if (last_in) in_frames_q <= in_frames_q + ONE;
                end
                if (out_pop && m_axis.tlast && frame_cnt != '1) frame_cnt <= frame_cnt + ONE;
                if (abort_ok) aborted <= 1'b1;
            end
        end
    end

    util_axis_skid u_skid (
        .clk        (aclk),
        .rst        (rst),
        .flush      (abort_ok),
        .in_enable  (state_d == ST_RUN),
        .in_valid   (s_axis_data.tvalid),
        .in_ready   (s_axis_data.tready),
        .in_word    (in_word),
        .out_valid  (m_axis.tvalid),
        .out_ready  (m_axis.tready),
        .out_word   (out_word),
        .empty_next (skid_empty_next)
    );

    assign m_axis.tdata = out_word.data;
    assign m_axis.tlast = out_word.tlast;
    assign m_axis.tuser = out_word.tuser;

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_util_axis_framer.sv
// Bench for util_axis_framer: table of capture vectors, random captures, and
// hand-written abort / reset / ignored-start sequences against a frame model.
module tb_util_axis_framer;
    import util_axis_pkg::*;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int W  = DW + 2;
    localparam logic [DW-1:0] SRC_BASE = 32'hA500_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [LW-1:0] cfg_frame_len = '0;
    logic [LW-1:0] cfg_num_frames = '0;
    logic          busy, done, aborted;
    logic [LW-1:0] frame_cnt;
    framer_state_e dbg_state;

    util_axis_framer_if #(.DATA_WIDTH(DW)) s_if ();
    util_axis_framer_if #(.DATA_WIDTH(DW)) m_if ();

    always #5 clk = ~clk;

    util_axis_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .aclk           (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_num_frames (cfg_num_frames),
        .s_axis_data    (s_if),
        .m_axis         (m_if),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .frame_cnt      (frame_cnt),
        .dbg_state      (dbg_state)
    );

    int          checks = 0;
    int          failures = 0;
    logic [W-1:0] exp_q[$];
    int unsigned src_idx = 0;
    int unsigned cyc = 0;
    int unsigned acc_cnt, hs_cnt, tlast_hs, done_cnt, hs_cyc, done_cyc;
    bit          s_acc_seen;

    typedef struct {
        int len;
        int num;
        int vmode;
        int rmode;
        bit poke;
        int exp_words;
        int exp_frames;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, want);
        end
    endtask

    // Word k of a capture whose first accepted sample is source index 'first'.
    function automatic logic [W-1:0] model_word(int unsigned k, int unsigned len, int unsigned first);
        logic [DW-1:0] d;
        logic          tl, tu;
        d  = SRC_BASE + DW'(first + k);
        tl = ((k % len) == len - 1);
        tu = ((k % len) == 0);
        return {d, tl, tu};
    endfunction

    function automatic logic pick(int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return 1'(($urandom_range(0, 1)));
    endfunction

    task automatic step();
        logic         m_hs, stall;
        logic [W-1:0] held, got;
        s_acc_seen = s_if.tvalid && s_if.tready;
        m_hs       = m_if.tvalid && m_if.tready;
        stall      = m_if.tvalid && !m_if.tready && !cfg_abort && !rst;
        held       = {m_if.tdata, m_if.tlast, m_if.tuser};
        if (m_hs) begin
            got = held;
            hs_cnt++;
            hs_cyc = cyc;
            if (m_if.tlast) tlast_hs++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected: got %0h required no word", got);
            end else begin
                chk("out_word", got, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_acc_seen) begin
            src_idx++;
            acc_cnt++;
        end
        s_if.tdata = SRC_BASE + DW'(src_idx);
        if (stall) chk("stall_hold", {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser}, {1'b1, held});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_counts();
        acc_cnt = 0; hs_cnt = 0; tlast_hs = 0; done_cnt = 0; hs_cyc = 0; done_cyc = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_tready"}, s_if.tready, 0);
        chk({tag, "_m_tvalid"}, m_if.tvalid, 0);
        chk({tag, "_m_tlast"}, m_if.tlast, 0);
        chk({tag, "_m_tuser"}, m_if.tuser, 0);
        chk({tag, "_m_tdata"}, m_if.tdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_aborted"}, aborted, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic start_capture(input int len, input int num);
        int unsigned first;
        first = src_idx;
        exp_q.delete();
        for (int k = 0; k < (num == 0 ? 120 : len * num); k++) exp_q.push_back(model_word(k, len, first));
        clear_counts();
        cfg_frame_len  = LW'(len);
        cfg_num_frames = LW'(num);
        cfg_start      = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("start_tready", s_if.tready, 1);
        chk("start_busy", busy, 1);
        chk("start_aborted_clear", aborted, 0);
    endtask

    task automatic run_capture(input vec_t v);
        int budget;
        bit ended;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        start_capture(v.len, v.num);
        budget = 0;
        ended  = 0;
        while (!ended && budget < 3000) begin
            s_if.tvalid = pick(v.vmode);
            m_if.tready = pick(v.rmode);
            if (v.poke && budget == 1) begin
                cfg_start      = 1'b1;
                cfg_frame_len  = LW'(v.len + 3);
                cfg_num_frames = '0;
            end
            step();
            cfg_start      = 1'b0;
            cfg_frame_len  = LW'(v.len);
            cfg_num_frames = LW'(v.num);
            if (s_acc_seen && acc_cnt == 1) begin
                chk("first_latency_valid", m_if.tvalid, 1);
                chk("first_tuser", m_if.tuser, 1);
            end
            if (s_acc_seen && acc_cnt == v.len * v.num) chk("s_tready_drop", s_if.tready, 0);
            if (done) ended = 1;
            budget++;
        end
        chk("done_seen", ended, 1);
        chk("busy_in_done", busy, 0);
        chk("done_timing", done_cyc, hs_cyc + 1);
        chk("words_out", hs_cnt, v.exp_words);
        chk("words_in", acc_cnt, v.exp_words);
        chk("exp_drained", exp_q.size(), 0);
        chk("frame_cnt", frame_cnt, v.exp_frames);
        s_if.tvalid = 1'b1;
        step();
        step();
        chk("done_once", done_cnt, 1);
        chk("busy_after", busy, 0);
        chk("frame_cnt_held", frame_cnt, v.exp_frames);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = SRC_BASE;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;

        vecs[0] = '{len: 4, num: 2, vmode: 0, rmode: 0, poke: 0, exp_words: 8,  exp_frames: 2};
        vecs[1] = '{len: 3, num: 1, vmode: 0, rmode: 1, poke: 0, exp_words: 3,  exp_frames: 1};
        vecs[2] = '{len: 1, num: 3, vmode: 0, rmode: 0, poke: 0, exp_words: 3,  exp_frames: 3};
        vecs[3] = '{len: 2, num: 2, vmode: 0, rmode: 0, poke: 1, exp_words: 4,  exp_frames: 2};
        vecs[4] = '{len: 6, num: 3, vmode: 2, rmode: 2, poke: 0, exp_words: 18, exp_frames: 3};

        clear_counts();
        repeat (3) step();
        check_reset("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_capture(vecs[i]);

        // Continuous single-word frames, ended by abort.
        start_capture(1, 0);
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        for (int b = 0; b < 500 && hs_cnt < 100; b++) step();
        chk("cont_words", hs_cnt, 100);
        chk("cont_frame_cnt", frame_cnt, 100);
        chk("cont_busy", busy, 1);
        chk("cont_no_done", done_cnt, 0);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        exp_q.delete();
        chk("cont_abort_tvalid", m_if.tvalid, 0);
        chk("cont_aborted", aborted, 1);
        chk("cont_abort_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            vec_t rv;
            rv.len = int'($urandom_range(1, 6));
            rv.num = int'($urandom_range(1, 4));
            rv.vmode = 2;
            rv.rmode = 2;
            rv.poke = 0;
            rv.exp_words = rv.len * rv.num;
            rv.exp_frames = rv.num;
            run_capture(rv);
        end

        // Abort with the output stalled, mid second frame.
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b0;
        start_capture(5, 4);
        m_if.tready = 1'b1;
        for (int b = 0; b < 50 && acc_cnt < 7; b++) step();
        chk("abort_accepts", acc_cnt, 7);
        m_if.tready = 1'b0;
        step();
        step();
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        exp_q.delete();
        chk("abort_tvalid", m_if.tvalid, 0);
        chk("abort_aborted", aborted, 1);
        chk("abort_busy", busy, 0);
        chk("abort_state", dbg_state, ST_IDLE);
        chk("abort_frame_cnt", frame_cnt, 1);
        chk("abort_s_tready", s_if.tready, 0);
        m_if.tready = 1'b1;
        begin
            int unsigned hs_before;
            hs_before = hs_cnt;
            repeat (5) step();
            chk("abort_no_done", done_cnt, 0);
            chk("abort_no_words", hs_cnt, hs_before);
        end

        // Zero-length start is ignored and leaves aborted set.
        cfg_frame_len  = '0;
        cfg_num_frames = LW'(1);
        cfg_start      = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        chk("len0_state", dbg_state, ST_IDLE);
        chk("len0_s_tready", s_if.tready, 0);
        chk("len0_busy", busy, 0);
        chk("len0_aborted_kept", aborted, 1);

        // Start and abort together from IDLE: nothing starts.
        cfg_frame_len = LW'(4);
        cfg_start     = 1'b1;
        cfg_abort     = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        step();
        chk("startabort_state", dbg_state, ST_IDLE);
        chk("startabort_s_tready", s_if.tready, 0);
        chk("startabort_busy", busy, 0);
        chk("startabort_aborted_kept", aborted, 1);

        // Reset in the middle of a len=8 frame.
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        start_capture(8, 1);
        repeat (4) step();
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        step();
        check_reset("midrst");
        rst = 1'b0;
        exp_q.delete();
        step();
        chk("midrst_idle_after", dbg_state, ST_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/util_axis_framer.md
# util_axis_framer

Streaming framer that consumes the free-running 32-bit sample stream from the single-port-ROM source (`s_axis_data_*`) and emits AXI-Stream frames of programmable length with `tlast`/`tuser` markers. It captures a programmed number of frames per start command, or runs continuously. It sits directly downstream of the ROM pattern source and upstream of DMA or packet sinks. A 2-entry skid buffer sustains 1 word/cycle with fully registered outputs.

## Interface
- `DATA_WIDTH`, 32, sample width.
- `LEN_WIDTH`, 16, width of frame-length and frame-count fields.
- `aclk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_start`  in  1  one-cycle pulse; starts a capture when in IDLE, ignored otherwise.
- `cfg_abort`  in  1  one-cycle pulse; terminates an active capture.
- `cfg_frame_len`  in  LEN_WIDTH  words per frame; sampled at start; 0 makes start ignored.
- `cfg_num_frames`  in  LEN_WIDTH  frames per capture; sampled at start; 0 means continuous.
- `s_axis_data_tvalid`  in  1  upstream word valid.
- `s_axis_data_tready`  out  1  upstream accept.
- `s_axis_data_tdata`  in  DATA_WIDTH  upstream word.
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tdata`  out  DATA_WIDTH  output word.
- `m_axis_tlast`  out  1  last word of frame.
- `m_axis_tuser`  out  1  first word of frame.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  sticky; set by abort, cleared by next accepted start or reset.
- `frame_cnt`  out  LEN_WIDTH  frames fully emitted (tlast handshaked) in the current capture.

## Operation
- Transfer rule: a word moves when valid && ready on the same edge, on either side.
- States are IDLE, RUN, DRAIN, DONE.
- IDLE → RUN: on `cfg_start` with `cfg_frame_len != 0`. On this transition, latch len and num_frames, clear word index, `frame_cnt` and `aborted`.
- RUN: `s_axis_data_tready` = !buffer_full_next. Each accepted word is tagged:
  - tuser = (word_idx == 0);
  - tlast = (word_idx == len-1);
  - word_idx wraps to 0 after tlast.
- RUN → DRAIN: on the accept of the tlast word of frame num_frames, counted at input. `s_axis_data_tready` drops the next cycle. This transition never occurs when num_frames = 0.
- DRAIN → DONE: when the buffer is empty and the final tlast has handshaked.
- DONE: `done` = 1 for one cycle, then → IDLE.
- Abort in RUN or DRAIN:
  - flush the buffer; `m_axis_tvalid` is low next cycle;
  - `aborted` = 1, → IDLE;
  - no `done`, no tlast emitted for the partial frame.
- Abort in IDLE or DONE: ignored.
- Start and abort in the same cycle: abort wins.
- `frame_cnt` increments on output tlast handshake and saturates at all-ones. `frame_cnt` is held after completion until the next start.
- len = 1: every word carries both tuser and tlast.
- Counters are LEN_WIDTH wide. Compare against len-1 using the latched value; no overflow path exists.

## Timing
- Reset values:
  - state = IDLE;
  - `s_axis_data_tready`, `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`, `busy`, `done`, `aborted` = 0;
  - `frame_cnt` = 0;
  - `m_axis_tdata` = 0;
  - buffer empty.
- `s_axis_data_tready` first goes high 1 cycle after the start pulse.
- Latency: a word accepted at edge N appears on `m_axis_*` after edge N (valid in cycle N+1) when the buffer is empty.
- All `m_axis_*` signals and `s_axis_data_tready` are registered; no combinational in→out path.
- Output stall: `m_axis_*` hold stable while tvalid && !tready.
- The skid buffer absorbs the single in-flight word when `m_axis_tready` drops. Sustained throughput is 1 word/cycle with tready held high.
- `busy` goes high the cycle after start, and low in the cycle `done` pulses or after abort.
- `rst` asserted mid-capture: next cycle equals the reset state; the partial frame is discarded.

## Structure
- Shared package `util_axis_pkg`: state enum (IDLE/RUN/DRAIN/DONE) and the tagged-word record {data, tlast, tuser}.
- Sub-module `util_axis_skid`: 2-entry skid buffer over the tagged word, with registered ready. The framer FSM and counters live in the top.

## Test plan
- len=4, num=2, upstream tvalid=1, tready=1: 8 words out back-to-back. tuser on words 0 and 4, tlast on 3 and 7. `done` pulses once 1 cycle after word 7. `frame_cnt`=2.
- len=3, num=1, `m_axis_tready` toggling 1/0 every cycle: data order preserved, no loss or duplication, outputs stable during stalls. `s_axis_data_tready` falls after the 3rd accept.
- len=1, num=0 (continuous), 100 cycles: every output word has tuser=tlast=1. `busy` stays high, no `done`, `frame_cnt`=100.
- len=5, num=4, abort after 7 accepted words with the output stalled: `m_axis_tvalid`=0 next cycle, `aborted`=1, `busy`=0, no `done`, `frame_cnt`=1.
- `cfg_frame_len`=0 start: stays IDLE, `s_axis_data_tready`=0. Then `rst` mid-frame of a len=8 capture: all outputs return to reset values the next cycle.
- Start pulsed during RUN: ignored. Start and abort in the same cycle from IDLE: no capture begins.
